// File: rtl/prog_mem_loadable.sv
// Program memory with a registered fetch port and a byte-serial loader (low byte, then high byte, then write).
// Define PROG_MEM_CHECKSUM_EN to add the ld_checksum output (16-bit running sum of the words written in a session).
module prog_mem_loadable #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_en,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [7:0]        ld_byte,
    input  logic              ld_byte_valid,
    output logic              ld_byte_ready,
    input  logic              ld_end,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count
`ifdef PROG_MEM_CHECKSUM_EN
    ,
    output logic [15:0]       ld_checksum
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              busy_cur, busy_nxt, mem_we;
`ifdef PROG_MEM_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    // State register plus loader and fetch datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Memory array has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= word_q;
        end
    end

    // Next-state logic. ld_end wins over a simultaneous byte in LO/HI; the byte is dropped.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
`ifdef PROG_MEM_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ld_start) begin
                    state_d = S_LO;
                    ptr_d   = ld_base;
                    cnt_d   = '0;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LO: begin
                if (ld_end) begin
                    state_d = S_DONE;
                end else if (ld_byte_valid) begin
                    word_d[7:0] = ld_byte;
                    state_d     = S_HI;
                end
            end
            S_HI: begin
                if (ld_end) begin
                    state_d = S_DONE;
                end else if (ld_byte_valid) begin
                    // Truncating cast keeps only the low DATA_W-8 bits of the high byte.
                    word_d  = DATA_W'({ld_byte, word_q[7:0]});
                    state_d = S_WR;
                end
            end
            S_WR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + (ADDR_W + 1)'(1);
                end
`ifdef PROG_MEM_CHECKSUM_EN
                sum_d = sum_q + 16'(word_q);
`endif
                state_d = S_LO;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs. Fetch is suppressed both while busy and on the edge that starts a session.
    always_comb begin
        busy_cur      = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_WR);
        busy_nxt      = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_WR);
        ld_byte_ready = (state_q == S_LO) || (state_q == S_HI);
        ld_done       = (state_q == S_DONE);
        mem_we        = (state_q == S_WR) && !rst;
        valid_d       = fetch_en && !busy_cur && !busy_nxt;
        instr_d       = valid_d ? mem[fetch_addr] : instr_q;
    end

    assign ld_busy     = busy_cur;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign ld_count    = cnt_q;
`ifdef PROG_MEM_CHECKSUM_EN
    assign ld_checksum = sum_q;
`endif

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Directed + randomized bench for prog_mem_loadable against an address-indexed word model.
module tb_prog_mem_loadable;

    localparam int DATA_W  = 14;
    localparam int ADDR_W  = 11;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int HI_MASK = (1 << (DATA_W - 8)) - 1;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_en;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [7:0]        ld_byte;
    logic              ld_byte_valid;
    logic              ld_byte_ready;
    logic              ld_end;
    logic              ld_busy;
    logic              ld_done;
    logic [ADDR_W:0]   ld_count;
`ifdef PROG_MEM_CHECKSUM_EN
    logic [15:0]       ld_checksum;
`endif

    prog_mem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_addr    (fetch_addr),
        .fetch_en      (fetch_en),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .ld_start      (ld_start),
        .ld_base       (ld_base),
        .ld_byte       (ld_byte),
        .ld_byte_valid (ld_byte_valid),
        .ld_byte_ready (ld_byte_ready),
        .ld_end        (ld_end),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done),
        .ld_count      (ld_count)
`ifdef PROG_MEM_CHECKSUM_EN
        ,
        .ld_checksum   (ld_checksum)
`endif
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: memory image, session pointer/count/sum, expected done pulses
    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] exp_mem [int];
    int m_ptr, m_cnt, m_sum, m_done;
    int sess_addrs[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ld_done === 1'b1) done_cnt++;
        if (ld_busy === 1'b1) check("valid_while_busy", 32'(instr_valid), 32'd0);
    end

    // Driver tasks; each begins and ends just after a falling edge.
    task automatic wait_ready();
        int t = 0;
        while (ld_byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", 32'(ld_byte_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        ld_byte       = b;
        ld_byte_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        ld_byte_valid = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] lo, input logic [7:0] hi);
        logic [DATA_W-1:0] w;
        send_byte(lo);
        send_byte(hi);
        w = DATA_W'(((int'(hi) & HI_MASK) << 8) | int'(lo));
        exp_mem[m_ptr] = w;
        sess_addrs.push_back(m_ptr);
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
        m_sum = (m_sum + int'(w)) & 'hFFFF;
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] base);
        ld_base  = base;
        ld_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld_start = 1'b0;
        m_ptr = int'(base);
        m_cnt = 0;
        m_sum = 0;
        sess_addrs.delete();
        check("busy_after_start", 32'(ld_busy), 32'd1);
    endtask

    task automatic end_session(input logic with_byte, input logic [7:0] b);
        wait_ready();
        ld_end        = 1'b1;
        ld_byte       = b;
        ld_byte_valid = with_byte;
        @(posedge clk);
        @(negedge clk);
        ld_end        = 1'b0;
        ld_byte_valid = 1'b0;
        m_done++;
        check("done_pulse", 32'(ld_done), 32'd1);
        check("busy_at_done", 32'(ld_busy), 32'd0);
        check("ready_at_done", 32'(ld_byte_ready), 32'd0);
        check("valid_at_done", 32'(instr_valid), 32'd0);
        check("count_at_done", 32'(ld_count), 32'(m_cnt));
`ifdef PROG_MEM_CHECKSUM_EN
        check("checksum_at_done", 32'(ld_checksum), 32'(m_sum));
`endif
    endtask

    task automatic idle_after_done();
        @(negedge clk);
        check("done_one_cycle", 32'(ld_done), 32'd0);
    endtask

    task automatic fetch_chk(input int addr);
        fetch_addr = ADDR_W'(addr);
        fetch_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_en = 1'b0;
        check("fetch_valid", 32'(instr_valid), 32'd1);
        if (exp_mem.exists(addr)) check($sformatf("fetch_data[%0h]", addr), 32'(instr_out), 32'(exp_mem[addr]));
    endtask

    initial begin
        int mode;
        int nw;
        int d0;
        int saved[$];
        rst = 1'b1; fetch_addr = '0; fetch_en = 1'b0; ld_start = 1'b0; ld_base = '0;
        ld_byte = '0; ld_byte_valid = 1'b0; ld_end = 1'b0;
        m_ptr = 0; m_cnt = 0; m_sum = 0; m_done = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_instr_out", 32'(instr_out), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(ld_busy), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_count", 32'(ld_count), 32'd0);
        check("rst_ready", 32'(ld_byte_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two words at base 0, then fetch address 1
        start_session(11'h000);
        load_word(8'h03, 8'h30);
        load_word(8'hA5, 8'h00);
        end_session(1'b0, 8'h00);
        check("basic_count", 32'(ld_count), 32'd2);
        idle_after_done();
        fetch_chk(1);
        check("basic_mem1", 32'(instr_out), 32'h00A5);
        fetch_chk(0);
        check("basic_mem0", 32'(instr_out), 32'h3003);
        @(negedge clk);
        check("fetch_idle_valid", 32'(instr_valid), 32'd0);
        check("fetch_idle_hold", 32'(instr_out), 32'h3003);

        // Pointer wrap from the top address
        start_session(11'h7FF);
        load_word(8'($urandom), 8'($urandom));
        load_word(8'($urandom), 8'($urandom));
        end_session(1'b0, 8'h00);
        check("wrap_count", 32'(ld_count), 32'd2);
        idle_after_done();
        fetch_chk(11'h7FF);
        fetch_chk(0);

        // End while in HI with a byte: half word dropped
        start_session(11'h000);
        send_byte(8'h24);
        end_session(1'b1, 8'h11);
        check("abort_hi_count", 32'(ld_count), 32'd0);
        idle_after_done();
        fetch_chk(0);

        // Reset while in HI after one complete word
        start_session(11'h7FE);
        load_word(8'($urandom), 8'($urandom));
        send_byte(8'($urandom));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_sum = 0;
        check("rst_hi_busy", 32'(ld_busy), 32'd0);
        check("rst_hi_done", 32'(ld_done), 32'd0);
        check("rst_hi_count", 32'(ld_count), 32'd0);
        check("rst_hi_valid", 32'(instr_valid), 32'd0);
        check("rst_hi_instr", 32'(instr_out), 32'd0);
        check("rst_hi_ready", 32'(ld_byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi_no_done", 32'(done_cnt), 32'(m_done));
        fetch_chk(11'h7FE);
        fetch_chk(11'h7FF);

        // fetch_en held through a session; stray ld_start while busy ignored
        fetch_addr = 11'h7FE;
        fetch_en   = 1'b1;
        @(negedge clk);
        check("pre_session_valid", 32'(instr_valid), 32'd1);
        start_session(11'h100);
        load_word(8'($urandom), 8'($urandom));
        wait_ready();
        ld_base  = 11'h200;
        ld_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld_start = 1'b0;
        check("start_ignored_busy", 32'(ld_busy), 32'd1);
        load_word(8'($urandom), 8'($urandom));
        end_session(1'b0, 8'h00);
        @(negedge clk);
        check("resume_valid", 32'(instr_valid), 32'd1);
        check("resume_data", 32'(instr_out), 32'(exp_mem[11'h7FE]));
        fetch_en = 1'b0;
        fetch_chk(11'h100);
        fetch_chk(11'h101);

        // ld_start during DONE goes straight to LO
        start_session(11'h300);
        load_word(8'($urandom), 8'($urandom));
        end_session(1'b0, 8'h00);
        start_session(11'h310);
        load_word(8'($urandom), 8'($urandom));
        end_session(1'b1, 8'($urandom));
        idle_after_done();
        fetch_chk(11'h300);
        fetch_chk(11'h310);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            start_session(ADDR_W'($urandom_range(0, DEPTH - 1)));
            nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) load_word(8'($urandom), 8'($urandom));
            mode = $urandom_range(0, 2);
            if (mode == 2) send_byte(8'($urandom));
            end_session(mode != 0, 8'($urandom));
            idle_after_done();
            saved = sess_addrs;
            foreach (saved[k]) fetch_chk(saved[k]);
        end

        // Count saturation at DEPTH; pointer keeps wrapping
        start_session(11'd5);
        for (int i = 0; i < DEPTH + 1; i++) load_word(8'($urandom), 8'($urandom));
        end_session(1'b0, 8'h00);
        check("sat_count", 32'(ld_count), 32'(DEPTH));
        idle_after_done();
        fetch_chk(5);
        fetch_chk(4);
        fetch_chk(6);

`ifdef PROG_MEM_CHECKSUM_EN
        start_session(11'h040);
        load_word(8'hFF, 8'h3F);
        load_word(8'h02, 8'h00);
        end_session(1'b0, 8'h00);
        check("checksum_value", 32'(ld_checksum), 32'h4001);
        idle_after_done();
        start_session(11'h050);
        check("checksum_cleared", 32'(ld_checksum), 32'h0000);
        end_session(1'b0, 8'h00);
        idle_after_done();
`endif

        @(negedge clk);
        #1;
        check("done_pulse_total", 32'(done_cnt), 32'(m_done));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
